// File: rtl/freq_pkg.sv
// Shared types and defaults for the clock-divider frequency meter.
package freq_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int DEF_EXPECT_PERIOD = 20;
    localparam int DEF_TOL           = 1;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser plus delay flop; emits 1-cycle rise/fall strobes
// for an input that is asynchronous to clk.
module edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic s1, s2, d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            d  <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            d  <= s2;
        end
    end

    assign rise = s2 & ~d;
    assign fall = ~s2 & d;

endmodule

// File: rtl/freq_meter.sv
// Measures period and high time of a slow square wave in clk cycles and
// reports lock once the period has matched its expected value long enough.
module freq_meter
    import freq_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int EXPECT_PERIOD = DEF_EXPECT_PERIOD,
    parameter int TOL           = DEF_TOL,
    parameter int LOCK_CNT      = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int               MC_W     = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [MC_W-1:0]  LOCK_M   = MC_W'(LOCK_CNT);
    localparam logic [CNT_W:0]   EXP_X    = (CNT_W+1)'(EXPECT_PERIOD);
    localparam logic [CNT_W:0]   TOL_X    = (CNT_W+1)'(TOL);
    // Compared in 64 bits so an override beyond the counter range never fires.
    localparam logic [63:0]      TO_LAST  = 64'(TIMEOUT - 1);

    logic             rise, fall;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic [CNT_W:0]   new_x, diff;
    logic             match, at_to, capture;
    logic [MC_W-1:0]  match_cnt, mc_inc, mc_d;
    state_t           state_q, state_d;
    logic             mv_d, locked_d, to_d;

    edge_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_in  (sig_in),
        .rise    (rise),
        .fall    (fall)
    );

    assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
    assign new_x   = {1'b0, cnt_inc};
    assign diff    = (new_x >= EXP_X) ? new_x - EXP_X : EXP_X - new_x;
    assign match   = (diff <= TOL_X);
    assign at_to   = (64'(cnt) == TO_LAST);
    assign mc_inc  = (match_cnt == LOCK_M) ? LOCK_M : match_cnt + MC_W'(1);

    always_comb begin
        state_d  = state_q;
        mc_d     = match_cnt;
        locked_d = locked;
        mv_d     = 1'b0;
        to_d     = 1'b0;
        capture  = 1'b0;
        case (state_q)
            SEARCH: begin
                // First edge has no reference; it only arms the meter.
                if (rise) state_d = MEASURE;
            end
            MEASURE, LOCKED: begin
                if (rise) begin
                    capture = 1'b1;
                    mv_d    = 1'b1;
                    if (match) begin
                        mc_d = mc_inc;
                        if (mc_inc == LOCK_M) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        mc_d     = '0;
                        state_d  = MEASURE;
                        locked_d = 1'b0;
                    end
                end else if (at_to) begin
                    state_d  = SEARCH;
                    to_d     = 1'b1;
                    locked_d = 1'b0;
                    mc_d     = '0;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SEARCH;
            cnt        <= '0;
            match_cnt  <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            match_cnt  <= mc_d;
            meas_valid <= mv_d;
            locked     <= locked_d;
            timeout    <= to_d;
            cnt        <= rise ? '0 : cnt_inc;
            if (capture) period    <= cnt_inc;
            if (fall)    high_time <= cnt_inc;
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: event-level reference model compared every cycle,
// directed scenarios with literal expectations, and randomized periods.
module tb_freq_meter;

    localparam longint EXP_P = 20;
    localparam longint TOL_P = 1;
    localparam int     LOCK_N = 4;
    localparam longint TO_P  = 255;
    localparam longint MAXV  = 65535;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        sig_in = 1'b0;
    logic [15:0] period, high_time;
    logic        meas_valid, locked, timeout;

    logic        rst2_n = 1'b1;
    logic        sig2 = 1'b0;
    logic [15:0] period2, high_time2;
    logic        mv2, locked2, to2;

    int errors = 0;
    int checks = 0;

    freq_meter dut (
        .clk(clk), .reset_n(reset_n), .sig_in(sig_in), .period(period),
        .high_time(high_time), .meas_valid(meas_valid), .locked(locked), .timeout(timeout)
    );

    freq_meter #(.CNT_W(16), .TIMEOUT(70000)) dut2 (
        .clk(clk), .reset_n(rst2_n), .sig_in(sig2), .period(period2),
        .high_time(high_time2), .meas_valid(mv2), .locked(locked2), .timeout(to2)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edge events by sample history, times by edge index.
    longint n = 0, last_ref = 0;
    bit     armed = 0;
    int     run = 0;
    bit     h1 = 0, h2 = 0, h3 = 0;
    longint m_period = 0, m_high = 0;
    bit     m_mv = 0, m_lock = 0, m_to = 0;

    initial forever begin
        longint elapsed, val, dv;
        bit r, f;
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            n = 0; last_ref = 0; armed = 0; run = 0;
            h1 = 0; h2 = 0; h3 = 0;
            m_period = 0; m_high = 0; m_mv = 0; m_lock = 0; m_to = 0;
        end else begin
            n++;
            elapsed = n - last_ref;
            val = (elapsed > MAXV) ? MAXV : elapsed;
            r = h2 & ~h3;
            f = ~h2 & h3;
            m_mv = 0;
            m_to = 0;
            if (r) begin
                if (armed) begin
                    m_period = val;
                    m_mv = 1;
                    dv = val - EXP_P;
                    if (dv < 0) dv = -dv;
                    if (dv <= TOL_P) begin
                        run++;
                        if (run >= LOCK_N) m_lock = 1;
                    end else begin
                        run = 0;
                        m_lock = 0;
                    end
                end
                armed = 1;
                last_ref = n;
            end else if (armed && elapsed == TO_P) begin
                m_to = 1; armed = 0; run = 0; m_lock = 0;
            end
            if (f) m_high = val;
            h3 = h2; h2 = h1; h1 = sig_in;
        end
    end

    // Per-cycle compare plus event monitors.
    longint mvq[$];
    bit     mvl[$];
    int     mv_total = 0, lock_at = -1, to_cnt = 0, to2_cnt = 0;
    bit     lock_seen = 0;
    longint cyc = 0, last_mv_cyc = 0, to_cyc = 0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!reset_n) begin
            chk("rst_period", period, 0);
            chk("rst_meas_valid", meas_valid, 0);
            chk("rst_locked", locked, 0);
        end else begin
            chk("period", period, m_period);
            chk("high_time", high_time, m_high);
            chk("meas_valid", meas_valid, m_mv);
            chk("locked", locked, m_lock);
            chk("timeout", timeout, m_to);
            if (meas_valid) begin
                mvq.push_back(period);
                mvl.push_back(locked);
                mv_total++;
                last_mv_cyc = cyc;
            end
            if (locked && !lock_seen) begin
                lock_seen = 1;
                lock_at = mv_total;
            end
            if (timeout) begin
                to_cnt++;
                to_cyc = cyc;
            end
        end
        if (to2) to2_cnt++;
    end

    task automatic drive(input int h, input int l);
        sig_in = 1'b1;
        repeat (h) @(negedge clk);
        sig_in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic chk_seq(input string name, input longint ep[], input bit el[]);
        chk({name, "_count"}, mvq.size(), ep.size());
        for (int i = 0; i < ep.size() && i < mvq.size(); i++) begin
            chk({name, "_period"}, mvq[i], ep[i]);
            chk({name, "_locked"}, mvl[i], el[i]);
        end
    endtask

    bit d2_done = 0;

    // Saturation scenario on a second instance with timeout out of reach.
    initial begin
        bit got;
        #1 rst2_n = 1'b0;
        repeat (3) @(negedge clk);
        rst2_n = 1'b1;
        sig2 = 1'b1;
        repeat (5) @(negedge clk);
        sig2 = 1'b0;
        repeat (66000) @(negedge clk);
        sig2 = 1'b1;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (mv2) begin
                got = 1;
                chk("sat_period", period2, 65535);
                chk("sat_high_time", high_time2, 5);
            end
        end
        chk("sat_meas_seen", got, 1);
        chk("sat_no_timeout", to2_cnt, 0);
        d2_done = 1;
    end

    initial begin
        int to0, h, l;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_high_time", high_time, 0);
        chk("reset_timeout", timeout, 0);
        reset_n = 1'b1;

        // Nominal divider output: lock on the 4th measurement.
        repeat (6) drive(10, 10);
        chk("t1_lock_at", lock_at, 4);
        chk("t1_period", period, 20);
        chk("t1_high", high_time, 10);
        chk("t1_locked", locked, 1);
        chk("t1_meas_count", mvq.size(), 5);

        // One long period breaks lock; four good ones restore it.
        mvq.delete(); mvl.delete();
        drive(11, 11);
        repeat (5) drive(10, 10);
        chk_seq("t2", '{20, 22, 20, 20, 20, 20}, '{1, 0, 0, 0, 0, 1});

        // Within tolerance keeps lock, 18 drops it.
        mvq.delete(); mvl.delete();
        drive(11, 10); drive(10, 9); drive(9, 9); drive(10, 10);
        chk_seq("t3", '{20, 21, 19, 18}, '{1, 1, 1, 0});

        // Loss of signal while locked.
        repeat (5) drive(10, 10);
        chk("t4_locked_before", locked, 1);
        to0 = to_cnt;
        repeat (400) @(negedge clk);
        chk("t4_timeout_count", to_cnt - to0, 1);
        chk("t4_timeout_delay", to_cyc - last_mv_cyc, 255);
        chk("t4_locked", locked, 0);
        chk("t4_period_held", period, 20);
        mvq.delete(); mvl.delete();
        drive(10, 10);
        chk("t4_rearm_no_meas", mvq.size(), 0);
        drive(10, 10);
        chk("t4_first_meas", mvq.size(), 1);

        // Asynchronous reset while locked, mid high phase.
        repeat (4) drive(10, 10);
        chk("t5_locked_before", locked, 1);
        sig_in = 1'b1;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        sig_in = 1'b0;
        #1;
        chk("t5_async_period", period, 0);
        chk("t5_async_high", high_time, 0);
        chk("t5_async_locked", locked, 0);
        @(negedge clk);
        reset_n = 1'b1;
        mvq.delete(); mvl.delete();
        drive(10, 10);
        chk("t5_rearm_no_meas", mvq.size(), 0);
        drive(10, 10);
        chk("t5_first_meas", mvq.size(), 1);

        // Rise on the timeout cycle wins.
        to0 = to_cnt;
        mvq.delete(); mvl.delete();
        drive(10, 245);
        drive(10, 10);
        chk("t6_meas_count", mvq.size(), 2);
        if (mvq.size() == 2) chk("t6_period", mvq[1], 255);
        chk("t6_no_timeout", to_cnt - to0, 0);

        // Randomized periods around nominal with occasional dropouts.
        repeat (60) begin
            h = $urandom_range(8, 12);
            l = $urandom_range(8, 12);
            if ($urandom_range(0, 9) == 0) l = $urandom_range(240, 300);
            drive(h, l);
        end
        repeat (300) @(negedge clk);

        for (int i = 0; i < 80000 && !d2_done; i++) @(negedge clk);
        chk("sat_done", d2_done, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
